// File: rtl/async_rx_os.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | async_rx_os : oversampling async serial receiver with majority-vote  |
// |               bit decisions and a READY/ACK word handshake.           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module async_rx_os #(
  parameter int WIDTH      = 10,
  parameter int OVERSAMPLE = 8,
  parameter int PARITY_EN  = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             RXD,
  input  logic             DATA_ACK,
  output logic [WIDTH-1:0] Frame,
  output logic             RX_BUSY,
  output logic             RX_READY,
  output logic             RX_ERROR
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(WIDTH + 1);

  localparam logic [2:0] c_S_IDLE   = 3'd0;
  localparam logic [2:0] c_S_START  = 3'd1;
  localparam logic [2:0] c_S_DATA   = 3'd2;
  localparam logic [2:0] c_S_PARITY = 3'd3;
  localparam logic [2:0] c_S_STOP   = 3'd4;

  localparam logic [CW-1:0] c_CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] c_CNT_S0   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] c_CNT_S1   = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] c_CNT_DEC  = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [BW-1:0] c_BIT_LAST = BW'(WIDTH - 1);
  localparam logic [2:0]    c_S_AFTER_DATA = (PARITY_EN != 0) ? c_S_PARITY : c_S_STOP;

  logic             r_sync1;
  logic             r_rxd_s;
  logic             r_rxd_s_d;
  logic [2:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [BW-1:0]    r_bitidx;
  logic [WIDTH-1:0] r_shift;
  logic             r_samp0;
  logic             r_samp1;
  logic             r_perr;
  logic [WIDTH-1:0] r_frame;
  logic             r_busy;
  logic             r_ready;
  logic             r_error;

  logic             w_start_edge;
  logic             w_maj;
  logic             w_decide;
  logic             w_bit_end;
  logic [2:0]       w_state_nxt;
  logic             w_done;
  logic             w_ferr;
  logic [WIDTH-1:0] w_shift_nxt;

  assign w_start_edge = r_rxd_s_d & ~r_rxd_s;
  // Third vote is the live synchronized sample at the decision count.
  assign w_maj     = (r_samp0 & r_samp1) | (r_samp0 & r_rxd_s) | (r_samp1 & r_rxd_s);
  assign w_decide  = (r_cnt == c_CNT_DEC);
  assign w_bit_end = (r_cnt == c_CNT_LAST);

  generate
    if (WIDTH > 1) begin : g_shift_wide
      assign w_shift_nxt = {w_maj, r_shift[WIDTH-1:1]};
    end else begin : g_shift_one
      assign w_shift_nxt = w_maj;
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      c_S_IDLE: begin
        if (w_start_edge) w_state_nxt = c_S_START;
      end
      c_S_START: begin
        if (w_decide && w_maj) w_state_nxt = c_S_IDLE;
        else if (w_bit_end)    w_state_nxt = c_S_DATA;
      end
      c_S_DATA: begin
        if (w_bit_end && (r_bitidx == c_BIT_LAST)) w_state_nxt = c_S_AFTER_DATA;
      end
      c_S_PARITY: begin
        if (w_bit_end) w_state_nxt = c_S_STOP;
      end
      c_S_STOP: begin
        // Frame completes at the stop decision, not at the end of the bit.
        if (w_decide) begin
          w_state_nxt = c_S_IDLE;
          w_done      = 1'b1;
          w_ferr      = ~w_maj;
        end
      end
      default: w_state_nxt = c_S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_sync1   <= 1'b1;
      r_rxd_s   <= 1'b1;
      r_rxd_s_d <= 1'b1;
      r_state   <= c_S_IDLE;
      r_cnt     <= '0;
      r_bitidx  <= '0;
      r_shift   <= '0;
      r_samp0   <= 1'b1;
      r_samp1   <= 1'b1;
      r_perr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_sync1   <= RXD;
      r_rxd_s   <= r_sync1;
      r_rxd_s_d <= r_rxd_s;
      r_state   <= w_state_nxt;
      r_busy    <= (w_state_nxt != c_S_IDLE);

      if (r_state == c_S_IDLE || w_state_nxt != r_state || w_bit_end) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end

      if (r_cnt == c_CNT_S0) r_samp0 <= r_rxd_s;
      if (r_cnt == c_CNT_S1) r_samp1 <= r_rxd_s;

      if (r_state == c_S_START) begin
        r_bitidx <= '0;
      end else if (r_state == c_S_DATA && w_bit_end) begin
        r_bitidx <= r_bitidx + BW'(1);
      end

      if (r_state == c_S_DATA && w_decide) r_shift <= w_shift_nxt;

      if (r_state == c_S_START) begin
        r_perr <= 1'b0;
      end else if (r_state == c_S_PARITY && w_decide) begin
        r_perr <= (^r_shift) ^ w_maj;
      end
    end
  end

  // A completing frame takes priority over an ACK in the same cycle.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_frame <= '0;
      r_ready <= 1'b0;
      r_error <= 1'b0;
    end else if (w_done) begin
      if (r_ready && !DATA_ACK) begin
        r_error <= 1'b1;
      end else begin
        r_frame <= r_shift;
        r_ready <= 1'b1;
        r_error <= r_perr | w_ferr;
      end
    end else if (DATA_ACK && r_ready) begin
      r_ready <= 1'b0;
      r_error <= 1'b0;
    end
  end

  assign Frame    = r_frame;
  assign RX_BUSY  = r_busy;
  assign RX_READY = r_ready;
  assign RX_ERROR = r_error;

endmodule
`default_nettype wire
